// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo_wr_arbiter block.
// Holds the FSM state enum, the stats counter width and the beat counter width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

  // beatCnt must be able to hold the value BurstLen
  function automatic int beat_cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requesting index searching upward
// from last_grant+1, wrapping modulo NumReq (NumReq need not be a power of two).
module rr_picker #(
  parameter int NumReq = 4,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    last_grant,
  output logic              any_req,
  output logic [IdW-1:0]    pick_id
);

  logic [IdW:0]   cand_sum [NumReq];
  logic [IdW-1:0] cand_id  [NumReq];

  // cand_id[gi] is the index examined at search distance gi+1 from last_grant
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, last_grant} + (IdW+1)'(gi + 1);
      assign cand_id[gi]  = (cand_sum[gi] >= (IdW+1)'(NumReq))
                          ? IdW'(cand_sum[gi] - (IdW+1)'(NumReq))
                          : cand_sum[gi][IdW-1:0];
    end
  endgenerate

  // Walk from the farthest candidate down so the nearest one wins
  always_comb begin
    any_req = 1'b0;
    pick_id = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req[cand_id[i]]) begin
        any_req = 1'b1;
        pick_id = cand_id[i];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NumReq producers.
// Define FIFO_ARB_STATS_EN to add per-producer saturating word counters on reqWords.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int NumReq    = 4,
  parameter int BurstLen  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             reqValid,
  input  logic [NumReq*DataWidth-1:0]   reqData,
  output logic [NumReq-1:0]             reqReady,
  input  logic                          fifoFull,
  output logic                          fifoWrEn,
  output logic [DataWidth-1:0]          fifoWrData,
  output logic                          grantValid,
  output logic [$clog2(NumReq)-1:0]     grantId
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NumReq*STATS_W-1:0]     reqWords
`endif
);

  localparam int IdW   = $clog2(NumReq);
  localparam int BeatW = beat_cnt_w(BurstLen);
  localparam logic [BeatW-1:0] LastBeat  = BeatW'(BurstLen - 1);
  localparam logic [IdW-1:0]   ResetLast = IdW'(NumReq - 1);

  arb_state_e       state_reg, state_next;
  logic [IdW-1:0]   grant_reg, grant_next;
  logic [IdW-1:0]   last_reg,  last_next;
  logic [BeatW-1:0] beat_reg,  beat_next;

  logic             any_req;
  logic [IdW-1:0]   pick_id;
  logic             xfer;

  logic [DataWidth-1:0] req_word [NumReq];

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_word
      assign req_word[gi] = reqData[gi*DataWidth +: DataWidth];
    end
  endgenerate

  rr_picker #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_picker (
    .req        (reqValid),
    .last_grant (last_reg),
    .any_req    (any_req),
    .pick_id    (pick_id)
  );

  // Write strobe is combinational so the FIFO full flag is honoured in the same cycle
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    beat_next  = beat_reg;
    reqReady   = '0;
    fifoWrEn   = 1'b0;
    xfer       = 1'b0;
    fifoWrData = req_word[grant_reg];
    if (state_reg == IDLE) begin
      if (any_req) begin
        grant_next = pick_id;
        beat_next  = '0;
        state_next = BURST;
      end
    end else begin
      xfer                = reqValid[grant_reg] & ~fifoFull;
      fifoWrEn            = xfer;
      reqReady[grant_reg] = xfer;
      if (xfer) begin
        beat_next = beat_reg + BeatW'(1);
      end
      // A full-stalled cycle with reqValid held neither counts nor releases
      if ((xfer && (beat_reg == LastBeat)) || !reqValid[grant_reg]) begin
        state_next = IDLE;
        last_next  = grant_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= ResetLast;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      beat_reg  <= beat_next;
    end
  end

  assign grantValid = (state_reg == BURST);
  assign grantId    = grant_reg;

`ifdef FIFO_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
      logic [STATS_W-1:0] words_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          words_reg <= '0;
        end else if (reqReady[gi] && (words_reg != '1)) begin
          words_reg <= words_reg + STATS_W'(1);
        end
      end
      assign reqWords[gi*STATS_W +: STATS_W] = words_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle behavioural model plus
// directed scenarios pinned by literal expectations and randomized traffic.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     reqValid;
  logic [NR*DW-1:0]  reqData;
  logic [NR-1:0]     reqReady;
  logic              fifoFull;
  logic              fifoWrEn;
  logic [DW-1:0]     fifoWrData;
  logic              grantValid;
  logic [1:0]        grantId;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  reqWords;
`endif

  fifo_wr_arbiter #(
    .DataWidth (DW),
    .NumReq    (NR),
    .BurstLen  (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqReady   (reqReady),
    .fifoFull   (fifoFull),
    .fifoWrEn   (fifoWrEn),
    .fifoWrData (fifoWrData),
    .grantValid (grantValid),
    .grantId    (grantId)
`ifdef FIFO_ARB_STATS_EN
    ,
    .reqWords   (reqWords)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Producer engine state
  int             rem [NR];
  int             seq [NR];
  int             pause [NR];
  int             pause_next [NR];
  bit             pres [NR];
  logic [DW-1:0]  base [NR];
  int             gap_pct  = 0;
  int             full_pct = 0;
  bit             acc [NR];

  // Behavioural model: who owns the port, beats so far, who went last
  bit  m_busy;
  int  m_gid, m_last, m_beats;
  int  m_words [NR];

  // Logs of what the DUT actually did
  int  dut_fifo [$];
  int  dut_cyc  [$];
  int  dut_gids [$];
  int  dut_beats[$];
  int  cyc = 0;
  int  first_valid_cyc = -1;
  bit  prev_gv = 1'b0;
  int  cur_beats = 0;
  bit  chk_on = 1'b0;
  bit  sb_on  = 1'b0;
  int  sb_next [NR];

  always @(negedge clk) begin
    logic [NR-1:0] e_ready;
    logic          e_wen;
    logic [DW-1:0] e_wdata;
    bit            xf;
    int            c;
    int            p;
    cyc++;
    e_ready = '0;
    e_wen   = 1'b0;
    e_wdata = '0;
    xf      = 1'b0;
    if (m_busy) begin
      xf      = reqValid[m_gid] && !fifoFull;
      e_wen   = xf;
      e_ready[m_gid] = xf;
      e_wdata = reqData[m_gid*DW +: DW];
    end
    if (chk_on) begin
      chk("reqReady", reqReady, e_ready);
      chk("fifoWrEn", fifoWrEn, e_wen);
      chk("grantValid", grantValid, m_busy);
      chk("grantId", grantId, m_gid);
      if (e_wen) chk("fifoWrData", fifoWrData, e_wdata);
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NR; i++) chk($sformatf("reqWords%0d", i), reqWords[i*16 +: 16], m_words[i]);
`endif
      if (fifoWrEn) begin
        dut_fifo.push_back(int'(fifoWrData));
        dut_cyc.push_back(cyc);
        if (sb_on) begin
          p = int'(fifoWrData[7:6]);
          chk($sformatf("order_p%0d", p), fifoWrData[5:0], sb_next[p] % 64);
          sb_next[p]++;
        end
      end
      if (grantValid && !prev_gv) dut_gids.push_back(int'(grantId));
      if (grantValid && fifoWrEn) cur_beats++;
      if (!grantValid && prev_gv) begin
        dut_beats.push_back(cur_beats);
        cur_beats = 0;
      end
      prev_gv = grantValid;
      if (first_valid_cyc < 0 && reqValid != '0) first_valid_cyc = cyc;
    end
    for (int i = 0; i < NR; i++) acc[i] = e_ready[i];
    // Advance the model by one clock edge
    if (rst) begin
      m_busy = 1'b0; m_gid = 0; m_last = NR - 1; m_beats = 0;
      for (int i = 0; i < NR; i++) m_words[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (e_ready[i] && m_words[i] < 65535) m_words[i]++;
      if (!m_busy) begin
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (reqValid[c]) begin
            m_busy = 1'b1; m_gid = c; m_beats = 0;
            break;
          end
        end
      end else begin
        if (xf) m_beats++;
        if ((xf && m_beats == BL) || !reqValid[m_gid]) begin
          m_busy = 1'b0;
          m_last = m_gid;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++; rem[i]--; pres[i] = 1'b0;
        pause[i] = pause_next[i]; pause_next[i] = 0;
      end
      if (!pres[i]) begin
        if (pause[i] > 0) pause[i]--;
        else if (rem[i] > 0 && $urandom_range(99) >= gap_pct) pres[i] = 1'b1;
      end
      reqValid[i] = pres[i];
      reqData[i*DW +: DW] = base[i] + seq[i][7:0];
    end
    if (full_pct > 0) fifoFull = ($urandom_range(99) < full_pct);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; pres[i] = 1'b0; end
    step();
    chk_on = 1'b1;
    step();
    for (int i = 0; i < NR; i++) begin seq[i] = 0; pause[i] = 0; pause_next[i] = 0; end
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    dut_fifo.delete(); dut_cyc.delete(); dut_gids.delete(); dut_beats.delete();
    first_valid_cyc = -1;
    cur_beats = 0;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (rem[i] > 0 || pres[i]) return 1'b0;
    return !m_busy;
  endfunction

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (!all_done() && n < bound) begin step(); n++; end
    chk({name, "_drain_in_time"}, (n < bound), 1);
    step(); step();
  endtask

  function automatic int qget(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic chk_list(input string name, input int q[$], input int e[$]);
    chk({name, "_len"}, q.size(), e.size());
    for (int k = 0; k < e.size(); k++) chk($sformatf("%s[%0d]", name, k), qget(q, k), e[k]);
  endtask

  task automatic chk_first_write(input string name);
    chk({name, "_latency"}, qget(dut_cyc, 0) - first_valid_cyc, 1);
  endtask

  function automatic void offsets(output int o[$]);
    o.delete();
    for (int k = 0; k < dut_cyc.size(); k++) o.push_back(dut_cyc[k] - dut_cyc[0]);
  endfunction

  initial begin
    int e[$];
    int o[$];
    rst = 1'b1; reqValid = '0; reqData = '0; fifoFull = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; seq[i] = 0; pause[i] = 0; pause_next[i] = 0; pres[i] = 1'b0;
      base[i] = '0; acc[i] = 1'b0; sb_next[i] = 0; m_words[i] = 0;
    end
    m_busy = 1'b0; m_gid = 0; m_last = NR - 1; m_beats = 0;

    // Reset state and single producer 2 presenting 0x10..0x15
    do_reset();
    @(negedge clk); #1;
    chk("rst_grantValid", grantValid, 0);
    chk("rst_grantId", grantId, 0);
    chk("rst_fifoWrEn", fifoWrEn, 0);
    chk("rst_reqReady", reqReady, 0);
    clear_logs();
    base[2] = 8'h10; rem[2] = 6;
    drain("single", 100);
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15}; chk_list("single_fifo", dut_fifo, e);
    e = '{2, 2};             chk_list("single_gids", dut_gids, e);
    e = '{4, 2};             chk_list("single_beats", dut_beats, e);
    offsets(o); e = '{0, 1, 2, 3, 5, 6}; chk_list("single_cyc", o, e);
    chk_first_write("single");

    // All four producers requesting continuously
    do_reset(); clear_logs();
    for (int i = 0; i < NR; i++) begin base[i] = 8'(i * 64); rem[i] = 8; end
    drain("all4", 200);
    e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_list("all4_gids", dut_gids, e);
    e = '{4, 4, 4, 4, 4, 4, 4, 4}; chk_list("all4_beats", dut_beats, e);
    offsets(o);
    e.delete();
    for (int k = 0; k < 32; k++) e.push_back(k + k / 4);
    chk_list("all4_cyc", o, e);

    // fifoFull held for 3 cycles after beat 2
    do_reset(); clear_logs();
    base[0] = 8'h20; rem[0] = 4;
    repeat (3) step();
    repeat (3) begin step(); fifoFull = 1'b1; end
    step(); fifoFull = 1'b0;
    drain("stall", 50);
    e = '{8'h20, 8'h21, 8'h22, 8'h23}; chk_list("stall_fifo", dut_fifo, e);
    e = '{0};                          chk_list("stall_gids", dut_gids, e);
    e = '{4};                          chk_list("stall_beats", dut_beats, e);
    offsets(o); e = '{0, 1, 5, 6};     chk_list("stall_cyc", o, e);
    chk_first_write("stall");

    // Producer 1 drops after one beat, then re-requests at once
    do_reset(); clear_logs();
    base[1] = 8'h50; rem[1] = 2; pause_next[1] = 1;
    base[2] = 8'h60; rem[2] = 2;
    drain("drop", 100);
    e = '{1, 2, 1};                        chk_list("drop_gids", dut_gids, e);
    e = '{1, 2, 1};                        chk_list("drop_beats", dut_beats, e);
    e = '{8'h50, 8'h60, 8'h61, 8'h51};     chk_list("drop_fifo", dut_fifo, e);

    // Reset pulsed during beat 2 of producer 3
    do_reset(); clear_logs();
    base[3] = 8'h70; rem[3] = 4;
    repeat (3) step();
    rst = 1'b1; base[0] = 8'h30; rem[0] = 2;
    step();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_grantValid", grantValid, 0);
    chk("midrst_reqReady", reqReady, 0);
    drain("midrst", 100);
    e = '{3, 0, 3};                                        chk_list("midrst_gids", dut_gids, e);
    e = '{2, 2, 2};                                        chk_list("midrst_beats", dut_beats, e);
    e = '{8'h70, 8'h71, 8'h30, 8'h31, 8'h72, 8'h73};       chk_list("midrst_fifo", dut_fifo, e);

    // Randomized traffic with gaps and fifoFull noise
    for (int r = 0; r < 2; r++) begin
      do_reset(); clear_logs();
      sb_on = 1'b1;
      gap_pct = (r == 0) ? 30 : 70;
      full_pct = 20;
      for (int i = 0; i < NR; i++) begin base[i] = 8'(i * 64); rem[i] = 40; sb_next[i] = 0; end
      drain($sformatf("rand%0d", r), 4000);
      full_pct = 0; fifoFull = 1'b0; gap_pct = 0;
      sb_on = 1'b0;
      chk($sformatf("rand%0d_total", r), dut_fifo.size(), 160);
      for (int i = 0; i < NR; i++) chk($sformatf("rand%0d_count_p%0d", r, i), sb_next[i], 40);
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturation of producer 0's word counter
    do_reset(); clear_logs();
    base[0] = 8'h00; rem[0] = 70000;
    drain("stats", 90000);
    chk("stats_sat_p0", reqWords[15:0], 16'hFFFF);
    for (int i = 1; i < NR; i++) chk($sformatf("stats_zero_p%0d", i), reqWords[i*16 +: 16], 0);
    clear_logs();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
